// File: rtl/hit_score_manager.sv
// rtl/hit_score_manager.sv - per-frame hit folding, lives/score bookkeeping and play state machine
module hit_score_manager #(
   parameter int INIT_LIVES    = 3,
   parameter int MAX_LIVES     = 5,
   parameter int COIN_POINTS   = 10,
   parameter int RING_POINTS   = 50,
   parameter int INVULN_FRAMES = 60
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        start_game,
   input  logic [2:0]  hit_type,
   output logic [2:0]  lives,
   output logic [15:0] score,
   output logic [1:0]  game_state,
   output logic        invulnerable,
   output logic        life_lost,
   output logic        game_over
);

   typedef enum logic [1:0] {
      S_WAIT = 2'd0,
      S_PLAY = 2'd1,
      S_HURT = 2'd2,
      S_OVER = 2'd3
   } state_t;

   localparam logic [2:0]  INIT_L   = 3'(INIT_LIVES);
   localparam logic [3:0]  MAX_L    = 4'(MAX_LIVES);
   localparam logic [16:0] COIN_ADD = 17'(COIN_POINTS);
   localparam logic [16:0] RING_ADD = 17'(RING_POINTS);
   localparam logic [7:0]  INV_LOAD = 8'(INVULN_FRAMES);

   state_t      state;
   logic [7:0]  inv_cnt;
   logic        acc_life, acc_coin, acc_good, acc_bad;
   logic        prev_life, prev_coin, prev_good;

   logic        hit_life, hit_coin, hit_good, hit_bad;
   logic        f_life, f_coin, f_good, f_bad;
   logic        life_edge, coin_edge, good_edge;
   logic [3:0]  lives_gain, lives_clamp, lives_down;
   logic [16:0] score_sum;
   logic [15:0] score_sat;
   logic        restart;

   // The code present in the startOfFrame cycle still belongs to the closing frame.
   always_comb begin
      hit_life    = (hit_type == 3'd1);
      hit_coin    = (hit_type == 3'd2);
      hit_good    = (hit_type == 3'd3);
      hit_bad     = (hit_type == 3'd4);
      f_life      = acc_life | hit_life;
      f_coin      = acc_coin | hit_coin;
      f_good      = acc_good | hit_good;
      f_bad       = acc_bad  | hit_bad;
      life_edge   = f_life & ~prev_life;
      coin_edge   = f_coin & ~prev_coin;
      good_edge   = f_good & ~prev_good;
      lives_gain  = {1'b0, lives} + {3'b000, life_edge};
      lives_clamp = (lives_gain > MAX_L) ? MAX_L : lives_gain;
      lives_down  = lives_clamp - 4'd1;
      score_sum   = {1'b0, score} + (coin_edge ? COIN_ADD : 17'd0)
                                  + (good_edge ? RING_ADD : 17'd0);
      score_sat   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      restart     = start_game && (state == S_WAIT || state == S_OVER);
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= S_WAIT;
         lives        <= INIT_L;
         score        <= 16'd0;
         inv_cnt      <= 8'd0;
         acc_life     <= 1'b0;
         acc_coin     <= 1'b0;
         acc_good     <= 1'b0;
         acc_bad      <= 1'b0;
         prev_life    <= 1'b0;
         prev_coin    <= 1'b0;
         prev_good    <= 1'b0;
         invulnerable <= 1'b0;
         life_lost    <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         life_lost <= 1'b0;
         if (restart) begin
            // A restart discards any frame update landing in the same cycle.
            state        <= S_PLAY;
            lives        <= INIT_L;
            score        <= 16'd0;
            inv_cnt      <= 8'd0;
            acc_life     <= 1'b0;
            acc_coin     <= 1'b0;
            acc_good     <= 1'b0;
            acc_bad      <= 1'b0;
            prev_life    <= 1'b0;
            prev_coin    <= 1'b0;
            prev_good    <= 1'b0;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
         end else if (startOfFrame) begin
            acc_life  <= 1'b0;
            acc_coin  <= 1'b0;
            acc_good  <= 1'b0;
            acc_bad   <= 1'b0;
            prev_life <= f_life;
            prev_coin <= f_coin;
            prev_good <= f_good;
            if (state == S_PLAY || state == S_HURT) begin
               lives <= lives_clamp[2:0];
               score <= score_sat;
               if (state == S_PLAY && f_bad) begin
                  lives     <= lives_down[2:0];
                  life_lost <= 1'b1;
                  if (lives_down == 4'd0) begin
                     state        <= S_OVER;
                     game_over    <= 1'b1;
                     invulnerable <= 1'b0;
                  end else begin
                     state        <= S_HURT;
                     inv_cnt      <= INV_LOAD;
                     invulnerable <= 1'b1;
                  end
               end else if (state == S_HURT) begin
                  inv_cnt <= inv_cnt - 8'd1;
                  if (inv_cnt <= 8'd1) begin
                     state        <= S_PLAY;
                     inv_cnt      <= 8'd0;
                     invulnerable <= 1'b0;
                  end
               end
            end
         end else begin
            acc_life <= acc_life | hit_life;
            acc_coin <= acc_coin | hit_coin;
            acc_good <= acc_good | hit_good;
            acc_bad  <= acc_bad  | hit_bad;
         end
      end
   end

   assign game_state = state;

endmodule

// File: tb/tb_hit_score_manager.sv
// tb/tb_hit_score_manager.sv - directed and random checks of hit_score_manager against a frame-level model
module tb_hit_score_manager;

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        startOfFrame = 1'b0;
   logic        start_game = 1'b0;
   logic [2:0]  hit_type = 3'd0;
   logic [2:0]  lives;
   logic [15:0] score;
   logic [1:0]  game_state;
   logic        invulnerable;
   logic        life_lost;
   logic        game_over;

   int checks = 0;
   int errors = 0;

   // Reference model: whole-frame rules in plain integers.
   int m_state, m_lives, m_score, m_inv;
   bit m_lost;
   bit m_acc  [5];
   bit m_prev [5];

   hit_score_manager dut (
      .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
      .hit_type(hit_type), .lives(lives), .score(score), .game_state(game_state),
      .invulnerable(invulnerable), .life_lost(life_lost), .game_over(game_over)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_state = 0; m_lives = 3; m_score = 0; m_inv = 0; m_lost = 0;
      for (int k = 0; k < 5; k++) begin m_acc[k] = 0; m_prev[k] = 0; end
   endfunction

   function automatic void model_step(input int ht, input bit sof, input bit sg);
      bit f [5];
      bit e [5];
      int code;
      code = (ht >= 1 && ht <= 4) ? ht : 0;
      m_lost = 0;
      if (sg && (m_state == 0 || m_state == 3)) begin
         m_state = 1; m_lives = 3; m_score = 0; m_inv = 0;
         for (int k = 0; k < 5; k++) begin m_acc[k] = 0; m_prev[k] = 0; end
      end else if (sof) begin
         for (int k = 0; k < 5; k++) f[k] = m_acc[k] || (code == k && k != 0);
         for (int k = 0; k < 5; k++) e[k] = f[k] && !m_prev[k];
         if (m_state == 1 || m_state == 2) begin
            if (e[1] && m_lives < 5) m_lives++;
            m_score = m_score + 10 * int'(e[2]) + 50 * int'(e[3]);
            if (m_score > 65535) m_score = 65535;
            if (m_state == 1 && f[4]) begin
               m_lives--; m_lost = 1;
               if (m_lives == 0) m_state = 3;
               else begin m_state = 2; m_inv = 60; end
            end else if (m_state == 2) begin
               m_inv--;
               if (m_inv == 0) m_state = 1;
            end
         end
         for (int k = 0; k < 5; k++) begin m_prev[k] = f[k]; m_acc[k] = 0; end
      end else begin
         for (int k = 1; k < 5; k++) if (code == k) m_acc[k] = 1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("lives", 32'(lives), m_lives);
      chk("score", 32'(score), m_score);
      chk("game_state", 32'(game_state), m_state);
      chk("invulnerable", 32'(invulnerable), (m_state == 2) ? 1 : 0);
      chk("life_lost", 32'(life_lost), 32'(m_lost));
      chk("game_over", 32'(game_over), (m_state == 3) ? 1 : 0);
   endtask

   task automatic step(input int ht, input bit sof, input bit sg);
      hit_type = 3'(ht); startOfFrame = sof; start_game = sg;
      @(posedge clk);
      model_step(ht, sof, sg);
      #1;
      check_all();
      startOfFrame = 1'b0; start_game = 1'b0;
   endtask

   task automatic frame(input int ht, input int len);
      for (int i = 0; i < len - 1; i++) step(ht, 1'b0, 1'b0);
      step(ht, 1'b1, 1'b0);
   endtask

   task automatic run_to_over();
      for (int i = 0; i < 400 && game_state != 2'd3; i++) frame(4, 1);
      chk("reach_over", 32'(game_state), 3);
   endtask

   initial begin
      model_reset();
      #12 resetN = 1'b1;
      check_all();

      // start and idle frame
      step(0, 0, 1);
      frame(0, 3);
      chk("idle_lives", 32'(lives), 3);
      chk("idle_state", 32'(game_state), 1);

      // coin reward fires on the rising edge only
      repeat (3) frame(2, 20);
      chk("coin_edge_once", 32'(score), 10);
      frame(0, 2);
      frame(2, 20);
      chk("coin_again", 32'(score), 20);

      // bring lives to the ceiling, then a mixed frame
      frame(1, 2); frame(0, 2); frame(1, 2); frame(0, 2);
      chk("lives_five", 32'(lives), 5);
      step(1, 0, 0); step(2, 0, 0); step(3, 1, 0);
      chk("mixed_lives", 32'(lives), 5);
      chk("mixed_score", 32'(score), 80);

      // damage and invulnerability window
      frame(4, 2);
      chk("hit_lives", 32'(lives), 4);
      chk("hit_pulse", 32'(life_lost), 1);
      chk("hit_state", 32'(game_state), 2);
      repeat (59) frame(4, 1);
      chk("hurt_hold_state", 32'(game_state), 2);
      chk("hurt_hold_lives", 32'(lives), 4);
      frame(4, 1);
      chk("hurt_exit_state", 32'(game_state), 1);
      chk("hurt_exit_lives", 32'(lives), 4);
      frame(4, 1);
      chk("second_hit", 32'(lives), 3);

      // game over, coins ignored, restart
      run_to_over();
      chk("over_lives", 32'(lives), 0);
      chk("over_flag", 32'(game_over), 1);
      frame(2, 3); frame(0, 1); frame(2, 3);
      chk("over_score", 32'(score), 80);
      step(0, 0, 1);
      chk("restart_lives", 32'(lives), 3);
      chk("restart_score", 32'(score), 0);
      chk("restart_state", 32'(game_state), 1);

      // randomized traffic
      for (int i = 0; i < 4000; i++)
         step(int'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 39) == 0));

      // score saturation
      run_to_over();
      step(0, 0, 1);
      repeat (1092) begin
         step(2, 0, 0); step(3, 0, 0); step(0, 1, 0); step(0, 1, 0);
      end
      chk("preload_score", 32'(score), 32'hFFF0);
      step(3, 1, 0);
      chk("sat_ring", 32'(score), 32'hFFFF);
      step(0, 1, 0); step(2, 1, 0);
      chk("sat_hold", 32'(score), 32'hFFFF);

      // start_game and startOfFrame together in OVER
      run_to_over();
      step(2, 0, 0);
      step(2, 1, 1);
      chk("collide_lives", 32'(lives), 3);
      chk("collide_score", 32'(score), 0);
      chk("collide_state", 32'(game_state), 1);
      step(0, 1, 0);
      chk("collide_no_coin", 32'(score), 0);

      // asynchronous reset mid-frame after a coin
      step(2, 0, 0); step(2, 0, 0);
      #2 resetN = 1'b0;
      model_reset();
      #1 check_all();
      chk("async_score", 32'(score), 0);
      #2 resetN = 1'b1;
      step(0, 1, 0);
      step(0, 0, 1);
      step(0, 1, 0);
      chk("post_reset_score", 32'(score), 0);
      chk("post_reset_state", 32'(game_state), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
